wb_sram_arb2: RTL and testbench
===============================

Name: wb_sram_arb2

Overview:
- Two-master Wishbone round-robin arbiter that shares one Wishbone slave port, normally the 16-bit SRAM bridge, between two masters (e.g. LM32 instruction and data buses).
- Sits between the interconnect slave slot and the SRAM bridge.
- Grant is registered and held for the whole bus cycle (cyc), so multi-beat and locked sequences are never split.

Parameters:
- adr_width, 32, address width of masters and slave.
- dat_width, 32, data width.
- timeout, 255, cycles a strobe may wait for ack/err before abort (only with WB_ARB_TIMEOUT_EN); 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_adr_i  in  adr_width  master 0 address
- m0_dat_i  in  dat_width  master 0 write data
- m0_dat_o  out  dat_width  master 0 read data
- m0_sel_i  in  dat_width/8  master 0 byte selects
- m0_we_i / m0_cyc_i / m0_stb_i  in  1 each  master 0 controls
- m0_ack_o / m0_err_o  out  1 each  master 0 termination
- m1_*  identical set for master 1
- s_adr_o / s_dat_o / s_sel_o / s_we_o / s_cyc_o / s_stb_o  out  as above  to slave
- s_dat_i  in  dat_width  slave read data
- s_ack_i / s_err_i  in  1 each  slave termination
- gnt_o  out  2  one-hot current grant, 00 = idle

Behaviour:
- States: IDLE, GNT0, GNT1. Reset: IDLE, last-served = 1 (m0 wins the first tie), gnt_o = 00, all acks, errs, s_cyc_o and s_stb_o = 0.
- IDLE: on the clock edge, if only mx_cyc_i = 1, go to GNTx. If both are 1, grant the master that was not last served. Arbitration latency is 1 cycle: s_cyc_o asserts the cycle after the request is seen.
- GNTx: s_adr/dat/sel/we are muxed from mx combinationally. s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i. Update last-served = x on entry.
- In IDLE the muxes select m0, with s_cyc_o = s_stb_o = 0.
- s_ack_i and s_err_i are routed only to the granted master. The non-granted master sees ack = err = 0.
- s_dat_i is broadcast to both m*_dat_o. A master may only sample it with its own ack.
- Grant held while mx_cyc_i = 1. When mx_cyc_i falls:
  - if the other master has cyc = 1, move directly to GNT(other) on the same edge (no idle bubble cycle, but one cycle with s_cyc_o = 0);
  - otherwise go to IDLE.
- No preemption. Round-robin guarantees each requester is served within one foreign cycle.
- Simultaneous fall of the granted cyc and rise of the other cyc: the other master wins on that edge.
- A new request from the just-served master in the same cycle loses a tie to the waiting master.
- Async reset mid-transfer: state goes to IDLE immediately and s_cyc_o/s_stb_o drop without waiting for a clock. A slave ack arriving during reset is discarded.
- gnt_o reflects the registered state: 01 = GNT0, 10 = GNT1.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on grant change and on s_ack_i or s_err_i, and increments while s_stb_o = 1 with no termination.
  - When the count reaches timeout: assert mx_err_o for exactly one cycle, force s_cyc_o = s_stb_o = 0, and block the slave until mx_cyc_i falls. Then arbitrate normally.
  - A late s_ack_i in that window is dropped.
- Undefined: no counter. err is pure pass-through and a hung slave holds the grant indefinitely.

Test Plan:
- m0 single read at 0x100, slave acks after 2 cycles with 0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc; m0_ack_o = 1 with m0_dat_o = 0xDEADBEEF; m1_ack_o stays 0; gnt_o = 01 then 00.
- m0 and m1 assert cyc in the same cycle after reset -> m0 granted first. After m0 drops cyc, gnt_o = 10 on the next edge. Repeat with both -> m1 then m0 (alternation).
- m1 holds cyc over 4 write strobes (sel = 0011, data 0x1..0x4) while m0 requests -> all 4 writes reach the slave before any m0 address appears; m0 served immediately after.
- Assert reset_n = 0 during a granted m1 write with stb high -> s_cyc_o/s_stb_o go 0 asynchronously; gnt_o = 00; no ack/err on either master after release.
- Slave returns s_err_i for m0 -> m0_err_o = 1 for 1 cycle; m1_err_o = 0; grant retained until m0 drops cyc.
- With WB_ARB_TIMEOUT_EN and timeout = 8, slave never acks m1 -> m1_err_o pulses on the 8th stalled cycle and s_cyc_o drops. A subsequent m0 request is served normally.

Source files
------------

// File: rtl/wb_sram_arb2.sv
// wb_sram_arb2: two-master Wishbone round-robin arbiter in front of one
// slave port (normally the 16-bit SRAM bridge). The grant is registered and
// held for the whole cyc of the owning master, so bursts are never split.
// Optional build macro WB_ARB_TIMEOUT_EN adds a stalled-strobe watchdog that
// errors the owning master and fences the slave until that master drops cyc.
module wb_sram_arb2 #(
   parameter int adr_width = 32,
   parameter int dat_width = 32,
   parameter int timeout   = 255
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [adr_width-1:0]   m0_adr_i,
   input  logic [dat_width-1:0]   m0_dat_i,
   output logic [dat_width-1:0]   m0_dat_o,
   input  logic [dat_width/8-1:0] m0_sel_i,
   input  logic                   m0_we_i,
   input  logic                   m0_cyc_i,
   input  logic                   m0_stb_i,
   output logic                   m0_ack_o,
   output logic                   m0_err_o,
   input  logic [adr_width-1:0]   m1_adr_i,
   input  logic [dat_width-1:0]   m1_dat_i,
   output logic [dat_width-1:0]   m1_dat_o,
   input  logic [dat_width/8-1:0] m1_sel_i,
   input  logic                   m1_we_i,
   input  logic                   m1_cyc_i,
   input  logic                   m1_stb_i,
   output logic                   m1_ack_o,
   output logic                   m1_err_o,
   output logic [adr_width-1:0]   s_adr_o,
   output logic [dat_width-1:0]   s_dat_o,
   output logic [dat_width/8-1:0] s_sel_o,
   output logic                   s_we_o,
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   input  logic [dat_width-1:0]   s_dat_i,
   input  logic                   s_ack_i,
   input  logic                   s_err_i,
   output logic [1:0]             gnt_o
);

   // Encoding doubles as the one-hot grant vector seen on gnt_o.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t state, state_next;
   logic   last_m1;
   logic   blocked;
   logic   hit;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] cnt;

   // The watchdog fires on the stalled cycle that would bring the count to timeout.
   assign hit = s_stb_o & ~s_ack_i & ~s_err_i & (cnt == 8'(timeout - 1));

   // Stall counter and slave fence; both are released whenever the grant moves.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= 8'd0;
         blocked <= 1'b0;
      end else begin
         if (state_next != state || s_ack_i || s_err_i) begin
            cnt <= 8'd0;
         end else if (s_stb_o) begin
            cnt <= cnt + 8'd1;
         end
         if (state_next != state) begin
            blocked <= 1'b0;
         end else if (hit) begin
            blocked <= 1'b1;
         end
      end
   end
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(timeout);
   assign hit     = 1'b0;
   assign blocked = 1'b0;
`endif

   // Grant register plus the round-robin memory of who was served last.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         last_m1 <= 1'b1;
      end else begin
         state <= state_next;
         if (state_next == GNT0) begin
            last_m1 <= 1'b0;
         end else if (state_next == GNT1) begin
            last_m1 <= 1'b1;
         end
      end
   end

   // Arbitration: hold while the owner keeps cyc, otherwise hand over or idle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_next = last_m1 ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_next = GNT0;
            end else if (m1_cyc_i) begin
               state_next = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_next = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_next = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Slave-side request mux; m0 is the idle default with the bus cycle parked.
   always_comb begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      case (state)
         GNT0: begin
            s_cyc_o = m0_cyc_i & ~blocked;
            s_stb_o = m0_stb_i & ~blocked;
         end
         GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i & ~blocked;
            s_stb_o = m1_stb_i & ~blocked;
         end
         default: ;
      endcase
   end

   // Terminations go only to the owner; read data is broadcast to both.
   always_comb begin
      m0_ack_o = (state == GNT0) & s_ack_i & ~blocked;
      m1_ack_o = (state == GNT1) & s_ack_i & ~blocked;
      m0_err_o = (state == GNT0) & ((s_err_i & ~blocked) | hit);
      m1_err_o = (state == GNT1) & ((s_err_i & ~blocked) | hit);
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      gnt_o    = state;
   end

endmodule

// File: tb/tb_wb_sram_arb2.sv
// tb_wb_sram_arb2: directed scenarios plus a randomized phase, all checked
// against a transaction-level ownership model of the round-robin arbiter.
module tb_wb_sram_arb2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
   logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
   logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
   logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [1:0]  gnt_o;

   int checkCount = 0;
   int errorCount = 0;
   int mOwner;
   int mLast;

   always #5 clk = ~clk;

   wb_sram_arb2 #(.adr_width(32), .dat_width(32), .timeout(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
      .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
      .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
   );

   // Single comparison point: counts every check and reports mismatches.
   task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Drives the handshake controls; data fields are set directly by callers.
   task applyStimulus(input logic c0, s0, c1, s1, ack, err);
      m0_cyc_i = c0;
      m0_stb_i = s0;
      m1_cyc_i = c1;
      m1_stb_i = s1;
      s_ack_i  = ack;
      s_err_i  = err;
   endtask

   // Expected outputs follow from who owns the bus and the live inputs.
   task checkAll();
      logic [1:0] eg;
      eg = (mOwner == 1) ? 2'b01 : (mOwner == 2) ? 2'b10 : 2'b00;
      checkOutput("gnt", {30'd0, gnt_o}, {30'd0, eg});
      checkOutput("s_cyc", {31'd0, s_cyc_o},
                  {31'd0, (mOwner == 1) ? m0_cyc_i : (mOwner == 2) ? m1_cyc_i : 1'b0});
      checkOutput("s_stb", {31'd0, s_stb_o},
                  {31'd0, (mOwner == 1) ? m0_stb_i : (mOwner == 2) ? m1_stb_i : 1'b0});
      checkOutput("s_adr", s_adr_o, (mOwner == 2) ? m1_adr_i : m0_adr_i);
      checkOutput("s_dat", s_dat_o, (mOwner == 2) ? m1_dat_i : m0_dat_i);
      checkOutput("s_sel", {28'd0, s_sel_o}, {28'd0, (mOwner == 2) ? m1_sel_i : m0_sel_i});
      checkOutput("s_we", {31'd0, s_we_o}, {31'd0, (mOwner == 2) ? m1_we_i : m0_we_i});
      checkOutput("m0_ack", {31'd0, m0_ack_o}, {31'd0, (mOwner == 1) && s_ack_i});
      checkOutput("m1_ack", {31'd0, m1_ack_o}, {31'd0, (mOwner == 2) && s_ack_i});
      checkOutput("m0_err", {31'd0, m0_err_o}, {31'd0, (mOwner == 1) && s_err_i});
      checkOutput("m1_err", {31'd0, m1_err_o}, {31'd0, (mOwner == 2) && s_err_i});
      checkOutput("m0_dat", m0_dat_o, s_dat_i);
      checkOutput("m1_dat", m1_dat_o, s_dat_i);
   endtask

   // Ownership changes only when the owner lets go; ties go to whoever waited.
   task modelEdge();
      if (!((mOwner == 1 && m0_cyc_i) || (mOwner == 2 && m1_cyc_i))) begin
         if (m0_cyc_i && m1_cyc_i) mOwner = (mLast == 1) ? 2 : 1;
         else if (m0_cyc_i) mOwner = 1;
         else if (m1_cyc_i) mOwner = 2;
         else mOwner = 0;
         if (mOwner != 0) mLast = mOwner;
      end
   endtask

   // One bus cycle: inputs were applied at the falling edge.
   task stepCycle();
      #1 checkAll();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   task doReset();
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      mOwner = 0;
      mLast  = 2;
      #12;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int stall;
      logic force_ack;
      m0_adr_i = 32'h0; m0_dat_i = 32'h0; m0_sel_i = 4'hF; m0_we_i = 1'b0;
      m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'hF; m1_we_i = 1'b0;
      s_dat_i = 32'h0;
      doReset();

      // Reset state
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1 checkOutput("rst_gnt", {30'd0, gnt_o}, 32'd0);
      checkOutput("rst_cyc", {31'd0, s_cyc_o}, 32'd0);
      stepCycle();

      // m0 single read at 0x100, ack after two granted cycles
      m0_adr_i = 32'h100;
      applyStimulus(1, 1, 0, 0, 0, 0);
      #1 checkOutput("t1_latency", {31'd0, s_cyc_o}, 32'd0);
      stepCycle();
      applyStimulus(1, 1, 0, 0, 0, 0);
      #1 checkOutput("t1_cyc", {31'd0, s_cyc_o}, 32'd1);
      stepCycle();
      s_dat_i = 32'hDEADBEEF;
      applyStimulus(1, 1, 0, 0, 1, 0);
      #1 checkOutput("t1_ack", {31'd0, m0_ack_o}, 32'd1);
      checkOutput("t1_dat", m0_dat_o, 32'hDEADBEEF);
      checkOutput("t1_m1ack", {31'd0, m1_ack_o}, 32'd0);
      checkOutput("t1_gnt", {30'd0, gnt_o}, 32'd1);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
      #1 checkOutput("t1_gnt_idle", {30'd0, gnt_o}, 32'd0);
      stepCycle();

      // Simultaneous requests after reset, then alternation
      doReset();
      applyStimulus(1, 1, 1, 1, 0, 0);
      stepCycle();
      #1 checkOutput("t2_first", {30'd0, gnt_o}, 32'd1);
      applyStimulus(1, 1, 1, 1, 1, 0);
      stepCycle();
      applyStimulus(0, 0, 1, 1, 0, 0);
      stepCycle();
      #1 checkOutput("t2_handover", {30'd0, gnt_o}, 32'd2);
      applyStimulus(0, 0, 1, 1, 1, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, 1, 1, 0, 0);
      stepCycle();
      #1 checkOutput("t2_alt_m0", {30'd0, gnt_o}, 32'd1);
      applyStimulus(1, 1, 0, 0, 1, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, 1, 1, 0, 0);
      stepCycle();
      #1 checkOutput("t2_alt_m1", {30'd0, gnt_o}, 32'd2);
      applyStimulus(1, 1, 0, 0, 0, 0);
      stepCycle();
      #1 checkOutput("t2_alt_back", {30'd0, gnt_o}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();

      // m1 burst of four writes while m0 waits
      doReset();
      m1_adr_i = 32'h300; m1_we_i = 1'b1; m1_sel_i = 4'b0011; m1_dat_i = 32'h1;
      m0_adr_i = 32'h200; m0_we_i = 1'b0;
      applyStimulus(0, 0, 1, 1, 0, 0);
      stepCycle();
      for (int i = 1; i <= 4; i++) begin
         m1_dat_i = i;
         applyStimulus(1, 1, 1, 1, 1, 0);
         #1 checkOutput("t3_wdat", s_dat_o, i);
         checkOutput("t3_adr", s_adr_o, 32'h300);
         stepCycle();
      end
      applyStimulus(1, 1, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, 0, 0, 1, 0);
      #1 checkOutput("t3_m0_next", {30'd0, gnt_o}, 32'd1);
      checkOutput("t3_m0_adr", s_adr_o, 32'h200);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();

      // Async reset during a granted m1 write
      applyStimulus(0, 0, 1, 1, 0, 0);
      stepCycle();
      applyStimulus(0, 0, 1, 1, 0, 0);
      #2 reset_n = 1'b0;
      s_ack_i = 1'b1;
      #1 checkOutput("t4_cyc", {31'd0, s_cyc_o}, 32'd0);
      checkOutput("t4_stb", {31'd0, s_stb_o}, 32'd0);
      checkOutput("t4_gnt", {30'd0, gnt_o}, 32'd0);
      checkOutput("t4_m1ack", {31'd0, m1_ack_o}, 32'd0);
      doReset();
      applyStimulus(0, 0, 0, 0, 1, 1);
      stepCycle();

      // Slave error on m0 while m1 is waiting
      m0_adr_i = 32'h40;
      applyStimulus(1, 1, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, 1, 1, 0, 1);
      #1 checkOutput("t5_err0", {31'd0, m0_err_o}, 32'd1);
      checkOutput("t5_err1", {31'd0, m1_err_o}, 32'd0);
      stepCycle();
      applyStimulus(1, 0, 1, 1, 0, 0);
      #1 checkOutput("t5_hold", {30'd0, gnt_o}, 32'd1);
      checkOutput("t5_err0_off", {31'd0, m0_err_o}, 32'd0);
      stepCycle();
      applyStimulus(0, 0, 1, 1, 1, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();

      // Randomized traffic with a slave that never stalls for long
      stall = 0;
      for (int n = 0; n < 400; n++) begin
         logic c0, c1, ack, err;
         c0 = ($urandom_range(0, 3) == 0) ? ~m0_cyc_i : m0_cyc_i;
         c1 = ($urandom_range(0, 3) == 0) ? ~m1_cyc_i : m1_cyc_i;
         force_ack = (stall >= 3);
         ack = force_ack || ($urandom_range(0, 2) == 0);
         err = !ack && ($urandom_range(0, 7) == 0);
         m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
         m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
         s_dat_i = $urandom;
         applyStimulus(c0, c0 & 1'($urandom), c1, c1 & 1'($urandom), ack, err);
         if (((mOwner == 1 && m0_stb_i) || (mOwner == 2 && m1_stb_i)) && !ack && !err) stall++;
         else stall = 0;
         stepCycle();
      end

`ifdef WB_ARB_TIMEOUT_EN
      // Hung slave under the watchdog, then normal service for m0
      doReset();
      applyStimulus(0, 0, 1, 1, 0, 0);
      stepCycle();
      for (int k = 1; k <= 8; k++) begin
         #1 checkOutput("to_err", {31'd0, m1_err_o}, {31'd0, k == 8});
         checkOutput("to_cyc", {31'd0, s_cyc_o}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      s_ack_i = 1'b1;
      #1 checkOutput("to_cyc_drop", {31'd0, s_cyc_o}, 32'd0);
      checkOutput("to_late_ack", {31'd0, m1_ack_o}, 32'd0);
      checkOutput("to_err_once", {31'd0, m1_err_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      mOwner = 2;
      mLast  = 2;
      applyStimulus(1, 1, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, 0, 0, 1, 0);
      #1 checkOutput("to_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
